// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
package uart_tx_arb_pkg;

   // Default number of idle OWN cycles before a grant is forcibly released
   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

   // IDLE: nobody granted; OWN: granted, no byte in flight; XFER: byte in flight
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_XFER = 2'd2
   } state_e;

endpackage

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter in front of a UART transmitter byte port.
// A granted requester may stream bytes one at a time; the grant is released at
// end of packet, when the requester lets go, or after TIMEOUT idle OWN cycles.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       wr0,
   input  logic       wr1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic       last0,
   input  logic       last1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] tx_data,
   output logic       tx_wr,
   input  logic       tx_done,
   output logic       busy,
   output logic       timeout_evt
);

   state_e      state_q, state_d;
   logic        gnt0_q, gnt0_d;
   logic        gnt1_q, gnt1_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_wr_q, tx_wr_d;
   logic        busy_q, busy_d;
   logic        timeout_evt_q, timeout_evt_d;
   logic [15:0] cnt_q, cnt_d;
   logic        last_served_q, last_served_d;
   logic        last_byte_q, last_byte_d;

   logic        owner;
   logic        own_req;
   logic        own_wr;
   logic [7:0]  own_data;
   logic        own_last;
   logic        pick;

   // The current owner is requester 1 exactly when gnt1 is held
   assign owner    = gnt1_q;
   assign own_req  = owner ? req1  : req0;
   assign own_wr   = owner ? wr1   : wr0;
   assign own_data = owner ? data1 : data0;
   assign own_last = owner ? last1 : last0;

   // On a tie the requester not served last wins; otherwise whoever is asking
   assign pick = (req0 && req1) ? ~last_served_q : req1;

   // Next-state and next-output computation; pulses default low every cycle
   always_comb begin
      state_d       = state_q;
      gnt0_d        = gnt0_q;
      gnt1_d        = gnt1_q;
      tx_data_d     = tx_data_q;
      tx_wr_d       = 1'b0;
      done0_d       = 1'b0;
      done1_d       = 1'b0;
      timeout_evt_d = 1'b0;
      cnt_d         = cnt_q;
      last_served_d = last_served_q;
      last_byte_d   = last_byte_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               gnt0_d        = ~pick;
               gnt1_d        = pick;
               last_served_d = pick;
               cnt_d         = 16'd0;
               state_d       = ST_OWN;
            end
         end
         ST_OWN: begin
            if (own_wr) begin
               tx_data_d   = own_data;
               tx_wr_d     = 1'b1;
               last_byte_d = own_last;
               state_d     = ST_XFER;
            end else if (!own_req) begin
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (cnt_q == TIMEOUT - 16'd1) begin
               gnt0_d        = 1'b0;
               gnt1_d        = 1'b0;
               timeout_evt_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_XFER: begin
            if (tx_done) begin
               done0_d = ~owner;
               done1_d = owner;
               if (last_byte_q || !own_req) begin
                  gnt0_d  = 1'b0;
                  gnt1_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = 16'd0;
                  state_d = ST_OWN;
               end
            end
         end
         default: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Register state and every output; reset forgets any byte in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         done0_q       <= 1'b0;
         done1_q       <= 1'b0;
         tx_data_q     <= 8'h00;
         tx_wr_q       <= 1'b0;
         busy_q        <= 1'b0;
         timeout_evt_q <= 1'b0;
         cnt_q         <= 16'd0;
         last_served_q <= 1'b1;
         last_byte_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt0_q        <= gnt0_d;
         gnt1_q        <= gnt1_d;
         done0_q       <= done0_d;
         done1_q       <= done1_d;
         tx_data_q     <= tx_data_d;
         tx_wr_q       <= tx_wr_d;
         busy_q        <= busy_d;
         timeout_evt_q <= timeout_evt_d;
         cnt_q         <= cnt_d;
         last_served_q <= last_served_d;
         last_byte_q   <= last_byte_d;
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign tx_data     = tx_data_q;
   assign tx_wr       = tx_wr_q;
   assign busy        = busy_q;
   assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and random checks for the UART transmit arbiter.
module tb_uart_tx_arb;

   logic       clk;
   logic       rst;
   logic       req0, req1, wr0, wr1, last0, last1, tx_done;
   logic [7:0] data0, data1;
   logic       gnt0, gnt1, done0, done1, tx_wr, busy, timeout_evt;
   logic [7:0] tx_data;

   int errors;
   int checks;

   uart_tx_arb #(.TIMEOUT(16'd16)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .data0(data0), .data1(data1), .last0(last0), .last1(last1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
      .busy(busy), .timeout_evt(timeout_evt)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r0, r1, w0, w1;
      logic [7:0] d0, d1;
      logic       l0, l1, td;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Packed output view: {gnt0,gnt1,tx_wr,tx_data,done0,done1,busy,timeout_evt}
   function automatic logic [14:0] outs();
      return {gnt0, gnt1, tx_wr, tx_data, done0, done1, busy, timeout_evt};
   endfunction

   function automatic vec_t mkVec(input logic r0, r1, w0, w1,
                                  input logic [7:0] d0, d1,
                                  input logic l0, l1, td, g0, g1, wr,
                                  input logic [7:0] txd,
                                  input logic dn0, dn1, bs, to);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
      v.d0 = d0; v.d1 = d1; v.l0 = l0; v.l1 = l1; v.td = td;
      v.exp = {g0, g1, wr, txd, dn0, dn1, bs, to};
      return v;
   endfunction

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      req0 = v.r0; req1 = v.r1; wr0 = v.w0; wr1 = v.w1;
      data0 = v.d0; data1 = v.d1; last0 = v.l0; last1 = v.l1; tx_done = v.td;
   endtask

   task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkValue(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; last0 = 0; last1 = 0;
      data0 = 8'h00; data1 = 8'h00; tx_done = 0;
   endtask

   // Random-traffic bookkeeping
   int  accepted, wrSeen, doneSeen, overlaps;
   bit  pending0, pending1, inflight;
   int  doneDelay;

   task automatic randomCycle(input bit active);
      bit fired;
      step();
      if (gnt0 && gnt1) overlaps++;
      if (done0) begin pending0 = 0; doneSeen++; end
      if (done1) begin pending1 = 0; doneSeen++; end
      if (tx_wr) begin
         wrSeen++;
         inflight  = 1;
         doneDelay = $urandom_range(0, 5);
      end
      wr0 = 0; wr1 = 0;
      if (active) begin
         if ($urandom_range(0, 7) == 0) req0 = ~req0;
         if ($urandom_range(0, 7) == 0) req1 = ~req1;
         data0 = 8'($urandom); data1 = 8'($urandom);
         last0 = ($urandom_range(0, 3) == 0); last1 = ($urandom_range(0, 3) == 0);
         if (gnt0 && !pending0 && $urandom_range(0, 3) == 0) begin
            wr0 = 1; req0 = 1; pending0 = 1; accepted++;
         end else if ((!gnt0 || pending0) && $urandom_range(0, 7) == 0) begin
            wr0 = 1;
         end
         if (gnt1 && !pending1 && $urandom_range(0, 3) == 0) begin
            wr1 = 1; req1 = 1; pending1 = 1; accepted++;
         end else if ((!gnt1 || pending1) && $urandom_range(0, 7) == 0) begin
            wr1 = 1;
         end
      end else begin
         req0 = 0; req1 = 0;
      end
      fired = 0;
      tx_done = 0;
      if (inflight) begin
         if (doneDelay == 0) begin
            tx_done = 1; inflight = 0; fired = 1;
         end else begin
            doneDelay--;
         end
      end
      if (!inflight && !fired && active && $urandom_range(0, 15) == 0) tx_done = 1;
   endtask

   int cnt;

   initial begin
      errors = 0;
      checks = 0;
      idleInputs();

      // Reset state
      rst = 1;
      repeat (3) step();
      checkOutput("reset_hold", outs(), 15'h0000);
      rst = 0;
      step();
      checkOutput("reset_release", outs(), 15'h0000);

      // Table of single-cycle vectors: tie arbitration, ignored writes, releases
      //                   r0 r1 w0 w1 d0     d1     l0 l1 td  g0 g1 wr txd    dn0 dn1 bs to
      vecs.push_back(mkVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0,  1, 0, 0, 8'h00, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 0, 1, 8'h00, 8'hCE, 0, 0, 0,  1, 0, 0, 8'h00, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 1, 0, 8'h81, 8'h00, 0, 0, 0,  1, 0, 1, 8'h81, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 1, 1, 8'h55, 8'hCE, 1, 1, 0,  1, 0, 0, 8'h81, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1,  1, 0, 0, 8'h81, 1,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 1, 0, 8'hBA, 8'h00, 1, 0, 0,  1, 0, 1, 8'hBA, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0,  1, 0, 0, 8'hBA, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1,  0, 0, 0, 8'hBA, 1,  0,  0, 0));
      vecs.push_back(mkVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0,  0, 1, 0, 8'hBA, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 0,  0, 1, 1, 8'h3C, 0,  0,  1, 0));
      vecs.push_back(mkVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1,  0, 0, 0, 8'h3C, 0,  1,  0, 0));
      vecs.push_back(mkVec(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0,  1, 0, 0, 8'h3C, 0,  0,  1, 0));
      vecs.push_back(mkVec(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0,  0, 0, 0, 8'h3C, 0,  0,  0, 0));
      vecs.push_back(mkVec(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0,  0, 1, 0, 8'h3C, 0,  0,  1, 0));
      vecs.push_back(mkVec(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1,  0, 1, 0, 8'h3C, 0,  0,  1, 0));
      vecs.push_back(mkVec(0, 1, 0, 1, 8'h00, 8'h77, 0, 0, 0,  0, 1, 1, 8'h77, 0,  0,  1, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0,  0, 1, 0, 8'h77, 0,  0,  1, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1,  0, 0, 0, 8'h77, 0,  1,  0, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0,  0, 0, 0, 8'h77, 0,  0,  0, 0));
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end
      idleInputs();

      // Two-byte packet from requester 0 with a slow transmitter
      req0 = 1;
      step();
      checkOutput("pkt_grant", outs(), {1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0});
      wr0 = 1; data0 = 8'h81; last0 = 0;
      step();
      wr0 = 0; data0 = 8'h00;
      checkOutput("pkt_wr1", outs(), {1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0});
      cnt = 0;
      for (int i = 0; i < 99; i++) begin
         step();
         if (tx_wr || done0) cnt++;
      end
      checkValue("pkt_quiet1", cnt, 0);
      tx_done = 1;
      step();
      tx_done = 0;
      checkOutput("pkt_done1", outs(), {1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0});
      step();
      checkOutput("pkt_done1_end", outs(), {1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0});
      wr0 = 1; data0 = 8'hBA; last0 = 1;
      step();
      wr0 = 0; data0 = 8'h00; last0 = 0;
      checkOutput("pkt_wr2", outs(), {1'b1, 1'b0, 1'b1, 8'hBA, 1'b0, 1'b0, 1'b1, 1'b0});
      repeat (99) step();
      tx_done = 1;
      step();
      tx_done = 0;
      checkOutput("pkt_done2", outs(), {1'b0, 1'b0, 1'b0, 8'hBA, 1'b1, 1'b0, 1'b0, 1'b0});
      req0 = 0;
      step();
      checkOutput("pkt_released", outs(), {1'b0, 1'b0, 1'b0, 8'hBA, 1'b0, 1'b0, 1'b0, 1'b0});

      // Timeout: requester 1 holds the grant without writing
      req1 = 1;
      step();
      checkOutput("to_grant1", outs(), {1'b0, 1'b1, 1'b0, 8'hBA, 1'b0, 1'b0, 1'b1, 1'b0});
      req0 = 1;
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!gnt1) break;
         cnt++;
      end
      checkValue("to_own_cycles", cnt, 16);
      checkOutput("to_event", outs(), {1'b0, 1'b0, 1'b0, 8'hBA, 1'b0, 1'b0, 1'b0, 1'b1});
      step();
      checkOutput("to_next_gnt0", outs(), {1'b1, 1'b0, 1'b0, 8'hBA, 1'b0, 1'b0, 1'b1, 1'b0});
      req0 = 0; req1 = 0;
      step();
      step();
      checkOutput("to_idle", outs(), {1'b0, 1'b0, 1'b0, 8'hBA, 1'b0, 1'b0, 1'b0, 1'b0});

      // Reset in the middle of a transfer abandons the byte
      req0 = 1;
      step();
      wr0 = 1; data0 = 8'h5A;
      step();
      wr0 = 0; data0 = 8'h00; req0 = 0;
      checkOutput("rx_inflight", outs(), {1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0});
      rst = 1;
      step();
      rst = 0;
      checkOutput("rx_reset", outs(), 15'h0000);
      tx_done = 1;
      step();
      tx_done = 0;
      checkOutput("rx_late_done", outs(), 15'h0000);
      step();
      checkOutput("rx_after", outs(), 15'h0000);

      // Random two-requester traffic
      accepted = 0; wrSeen = 0; doneSeen = 0; overlaps = 0;
      pending0 = 0; pending1 = 0; inflight = 0; doneDelay = 0;
      for (int i = 0; i < 10000; i++) randomCycle(1'b1);
      for (int i = 0; i < 30; i++) randomCycle(1'b0);
      checkValue("rnd_overlap", overlaps, 0);
      checkValue("rnd_txwr_count", wrSeen, accepted);
      checkValue("rnd_done_count", doneSeen, accepted);
      idleInputs();
      step();
      checkValue("rnd_idle_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
